// File: rtl/inter_tx_arbiter_pkg.sv
// rtl/inter_tx_arbiter_pkg.sv - shared widths, requester indices and FSM encodings for the interboard tx arbiter
//
// Contents:
//   X_W/Y_W/MSG_W/CARD_W/SEL_W  payload field widths of an interboard message
//   req_idx_e                   requester index (shift, move, draw, end-turn)
//   ST_*                        arbiter FSM state encodings
//   ctrl_payload_t              one latched interboard message
//   req_onehot()                index to one-hot requester vector
package inter_tx_arbiter_pkg;

    localparam int X_W    = 5;
    localparam int Y_W    = 3;
    localparam int MSG_W  = 4;
    localparam int CARD_W = 6;
    localparam int SEL_W  = 3;

    localparam int NUM_REQ_FIXED = 4;
    localparam int REQ_IDX_W     = 2;

    typedef enum logic [REQ_IDX_W-1:0] {
        REQ_SHIFT = 2'd0,
        REQ_MOVE  = 2'd1,
        REQ_DRAW  = 2'd2,
        REQ_END   = 2'd3
    } req_idx_e;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef struct packed {
        logic              move_dir;
        logic [X_W-1:0]    block_x;
        logic [Y_W-1:0]    block_y;
        logic [MSG_W-1:0]  msg_type;
        logic [CARD_W-1:0] card;
        logic [SEL_W-1:0]  sel_len;
    } ctrl_payload_t;

    function automatic logic [NUM_REQ_FIXED-1:0] req_onehot(input logic [REQ_IDX_W-1:0] idx);
        return NUM_REQ_FIXED'(1) << idx;
    endfunction

endpackage

// File: rtl/inter_tx_arbiter_if.sv
// rtl/inter_tx_arbiter_if.sv - handler-side requests and transmitter-side launch bus of the tx arbiter
//
// Signals:
//   req, req_*          per-requester request level and flattened payload (requester i at [W*i +: W])
//   inter_ready         interboard transmitter idle (1) / busy (0)
//   done                one-hot completion pulse to the granted requester
//   busy                arbiter not idle
//   ctrl_en, ctrl_*     launch pulse and latched payload toward the transmitter
// Modports:
//   master              handlers + transmitter side
//   slave               arbiter side
interface inter_tx_arbiter_if
    import inter_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_FIXED
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_move_dir;
    logic [X_W*NUM_REQ-1:0]    req_block_x;
    logic [Y_W*NUM_REQ-1:0]    req_block_y;
    logic [MSG_W*NUM_REQ-1:0]  req_msg_type;
    logic [CARD_W*NUM_REQ-1:0] req_card;
    logic [SEL_W*NUM_REQ-1:0]  req_sel_len;
    logic                      inter_ready;

    logic [NUM_REQ-1:0]        done;
    logic                      busy;
    logic                      ctrl_en;
    logic                      ctrl_move_dir;
    logic [X_W-1:0]            ctrl_block_x;
    logic [Y_W-1:0]            ctrl_block_y;
    logic [MSG_W-1:0]          ctrl_msg_type;
    logic [CARD_W-1:0]         ctrl_card;
    logic [SEL_W-1:0]          ctrl_sel_len;

    modport master (
        output req, req_move_dir, req_block_x, req_block_y, req_msg_type, req_card, req_sel_len,
        output inter_ready,
        input  done, busy, ctrl_en,
        input  ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len
    );

    modport slave (
        input  req, req_move_dir, req_block_x, req_block_y, req_msg_type, req_card, req_sel_len,
        input  inter_ready,
        output done, busy, ctrl_en,
        output ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len
    );

endinterface

// File: rtl/inter_tx_arbiter_rr_select.sv
// rtl/inter_tx_arbiter_rr_select.sv - combinational round-robin winner search
//
// Ports:
//   req     request vector
//   rr_ptr  index searched first; search wraps upward
//   valid   at least one request present
//   winner  first requesting index at or after rr_ptr
module rr_select
    import inter_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_FIXED,
    parameter int IDX_W   = REQ_IDX_W
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    // Walk from the farthest candidate back to rr_ptr so the closest
    // requester overwrites the others. The index add wraps naturally
    // because NUM_REQ is exactly 2**IDX_W.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[rr_ptr + IDX_W'(i)]) begin
                valid  = 1'b1;
                winner = rr_ptr + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/inter_tx_arbiter.sv
// rtl/inter_tx_arbiter.sv - round-robin owner of the single interboard transmit channel
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   interboard_rst  synchronous active-high reset, same effect as rst
//   bus             slave side of inter_tx_arbiter_if (requests in, launch/done out)
// Parameters:
//   NUM_REQ         requester count (4: shift, move, draw, end-turn)
//   BUSY_TIMEOUT    cycles to wait for inter_ready to drop after a launch
module inter_tx_arbiter
    import inter_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_FIXED,
    parameter int BUSY_TIMEOUT = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              interboard_rst,
    inter_tx_arbiter_if.slave bus
);

    localparam int              CNT_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [REQ_IDX_W-1:0] rr_ptr;
    logic [REQ_IDX_W-1:0] grant_idx;
    logic [REQ_IDX_W-1:0] winner;
    logic                 sel_valid;
    logic [CNT_W-1:0]     busy_cnt;
    ctrl_payload_t        req_payload;
    ctrl_payload_t        ctrl_q;
    logic                 ctrl_en_q;
    logic                 busy_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 sync_rst;

    assign sync_rst = rst | interboard_rst;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_W)
    ) u_rr_select (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .valid  (sel_valid),
        .winner (winner)
    );

    // Payload of the current round-robin winner, latched only on grant.
    always_comb begin
        req_payload          = '0;
        req_payload.move_dir = bus.req_move_dir[winner];
        req_payload.block_x  = bus.req_block_x[int'(winner)*X_W +: X_W];
        req_payload.block_y  = bus.req_block_y[int'(winner)*Y_W +: Y_W];
        req_payload.msg_type = bus.req_msg_type[int'(winner)*MSG_W +: MSG_W];
        req_payload.card     = bus.req_card[int'(winner)*CARD_W +: CARD_W];
        req_payload.sel_len  = bus.req_sel_len[int'(winner)*SEL_W +: SEL_W];
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                // A busy channel blocks granting even when requests are pending.
                if (bus.inter_ready && sel_valid) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A transfer short enough to never show busy is closed out by the timeout.
                if (!bus.inter_ready) begin
                    state_next = ST_WAIT_DONE;
                end else if (busy_cnt == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.inter_ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from state_next so each pulse lines up with
    // the cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            busy_cnt  <= '0;
            ctrl_q    <= '0;
            ctrl_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= '0;
        end else begin
            state     <= state_next;
            ctrl_en_q <= (state_next == ST_SEND);
            busy_q    <= (state_next != ST_IDLE);
            done_q    <= (state_next == ST_DONE) ? req_onehot(grant_idx) : '0;
            case (state)
                ST_IDLE: begin
                    if (state_next == ST_SEND) begin
                        grant_idx <= winner;
                        ctrl_q    <= req_payload;
                    end
                end
                ST_SEND: begin
                    busy_cnt <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (bus.inter_ready && busy_cnt != CNT_LAST) begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    rr_ptr <= grant_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done          = done_q;
    assign bus.busy          = busy_q;
    assign bus.ctrl_en       = ctrl_en_q;
    assign bus.ctrl_move_dir = ctrl_q.move_dir;
    assign bus.ctrl_block_x  = ctrl_q.block_x;
    assign bus.ctrl_block_y  = ctrl_q.block_y;
    assign bus.ctrl_msg_type = ctrl_q.msg_type;
    assign bus.ctrl_card     = ctrl_q.card;
    assign bus.ctrl_sel_len  = ctrl_q.sel_len;

endmodule

// File: tb/tb_inter_tx_arbiter.sv
// tb/tb_inter_tx_arbiter.sv - self-checking bench for inter_tx_arbiter
module tb_inter_tx_arbiter;
    import inter_tx_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int BT = 16;

    typedef struct packed {
        logic [1:0]  idx;
        logic [21:0] pay;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    logic interboard_rst;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_en = 0;
    int   n_done = 0;
    int   last_grant = 0;
    bit   outstanding = 1'b0;
    sb_t  exp_q[$];

    logic       md[NR];
    logic [4:0] bx[NR];
    logic [2:0] by[NR];
    logic [3:0] mt[NR];
    logic [5:0] cd[NR];
    logic [2:0] sl[NR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inter_tx_arbiter_if #(.NUM_REQ(NR)) bus();

    inter_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .bus            (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({bus.done, bus.busy, bus.ctrl_en, bus.ctrl_move_dir, bus.ctrl_block_x,
                    bus.ctrl_block_y, bus.ctrl_msg_type, bus.ctrl_card, bus.ctrl_sel_len});
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_move_dir[i]        = md[i];
            bus.req_block_x[i*5 +: 5]  = bx[i];
            bus.req_block_y[i*3 +: 3]  = by[i];
            bus.req_msg_type[i*4 +: 4] = mt[i];
            bus.req_card[i*6 +: 6]     = cd[i];
            bus.req_sel_len[i*3 +: 3]  = sl[i];
        end
    endtask

    task automatic push(input int i);
        sb_t e;
        e.idx = 2'(i);
        e.pay = {md[i], bx[i], by[i], mt[i], cd[i], sl[i]};
        exp_q.push_back(e);
    endtask

    task automatic wait_en(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.ctrl_en) begin
                at = cyc;
                break;
            end
        end
        check(tag, 32'(at >= 0), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                at = cyc;
                break;
            end
        end
        check(tag, 32'(at >= 0), 32'd1);
    endtask

    // Scoreboard: every launch pops the next expected message, every done must
    // target the requester of the last launch, and launches never overlap.
    always @(negedge clk) begin
        sb_t e;
        logic [3:0] exp_done;
        if (rst || interboard_rst) begin
            outstanding = 1'b0;
        end else begin
            if (bus.ctrl_en) begin
                n_en++;
                check("no_double_launch", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    last_grant = int'(e.idx);
                    check("launch_payload",
                          32'({bus.ctrl_move_dir, bus.ctrl_block_x, bus.ctrl_block_y,
                               bus.ctrl_msg_type, bus.ctrl_card, bus.ctrl_sel_len}),
                          32'(e.pay));
                end
            end
            if (bus.done != '0) begin
                n_done++;
                exp_done = 4'b0001 << last_grant;
                check("done_target", 32'(bus.done), 32'(exp_done));
                outstanding = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, end of test not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int dc;
        int t0;
        int prev_done;

        rst = 1'b1;
        interboard_rst = 1'b0;
        bus.req = '0;
        bus.inter_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            md[i] = 1'(i);
            bx[i] = 5'(i * 3 + 2);
            by[i] = 3'(i + 1);
            mt[i] = 4'(i + 8);
            cd[i] = 6'(i * 11 + 5);
            sl[i] = 3'(7 - i);
        end
        drive();
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", out_vec(), 32'd0);

        // Single request from shift handler.
        bx[0] = 5'd7;
        mt[0] = 4'd3;
        drive();
        push(int'(REQ_SHIFT));
        bus.req = 4'b0001;
        t0 = cyc;
        wait_en("single_launch_seen", 4, at);
        check("single_grant_latency", 32'(at - t0), 32'd1);
        check("single_block_x", 32'(bus.ctrl_block_x), 32'd7);
        check("single_msg_type", 32'(bus.ctrl_msg_type), 32'd3);
        @(negedge clk);
        check("single_en_one_pulse", 32'(bus.ctrl_en), 32'd0);
        bus.inter_ready = 1'b0;
        repeat (5) @(negedge clk);
        bus.inter_ready = 1'b1;
        @(negedge clk);
        check("single_done", 32'(bus.done), 32'b0001);
        check("single_done_latency", 32'(cyc - at), 32'd7);
        bus.req = '0;
        @(negedge clk);
        check("single_idle_busy", 32'(bus.busy), 32'd0);
        check("single_payload_hold", 32'(bus.ctrl_block_x), 32'd7);

        // Round robin from rr_ptr=0 with all four requesting.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) push(k % 4);
        bus.req = 4'b1111;
        prev_done = -1;
        for (int k = 0; k < 5; k++) begin
            wait_en("rr_launch_seen", 8, at);
            if (prev_done >= 0) check("rr_next_grant_gap", 32'(at - prev_done), 32'd2);
            @(negedge clk);
            bus.inter_ready = 1'b0;
            repeat (2) @(negedge clk);
            bus.inter_ready = 1'b1;
            wait_done("rr_done_seen", 8, dc);
            check("rr_done_order", 32'(bus.done), 32'(4'b0001 << (k % 4)));
            prev_done = dc;
            bus.req[k % 4] = 1'b0;
            @(negedge clk);
            if (k < 4) bus.req[k % 4] = 1'b1;
            else bus.req = '0;
        end

        // Timeout: inter_ready never drops after launch.
        push(int'(REQ_END));
        bus.req = 4'b1000;
        wait_en("timeout_launch_seen", 4, at);
        wait_done("timeout_done_seen", BT + 8, dc);
        check("timeout_latency", 32'(dc - at), 32'(BT + 1));
        check("timeout_done", 32'(bus.done), 32'b1000);
        bus.req = '0;
        @(negedge clk);

        // Channel busy when the request arrives.
        bus.inter_ready = 1'b0;
        bus.req = 4'b0100;
        push(int'(REQ_DRAW));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("chbusy_no_launch", 32'(bus.ctrl_en), 32'd0);
        end
        bus.inter_ready = 1'b1;
        @(negedge clk);
        check("chbusy_launch", 32'(bus.ctrl_en), 32'd1);
        @(negedge clk);
        bus.inter_ready = 1'b0;
        @(negedge clk);
        bus.inter_ready = 1'b1;
        wait_done("chbusy_done_seen", 8, dc);
        check("chbusy_done", 32'(bus.done), 32'b0100);
        bus.req = '0;
        @(negedge clk);

        // interboard_rst while waiting for the transmitter to finish.
        push(int'(REQ_END));
        bus.req = 4'b1000;
        wait_en("rst_launch_seen", 4, at);
        @(negedge clk);
        bus.inter_ready = 1'b0;
        repeat (2) @(negedge clk);
        interboard_rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", out_vec(), 32'd0);
        interboard_rst = 1'b0;
        bus.inter_ready = 1'b1;
        bus.req = 4'b1010;
        push(int'(REQ_MOVE));
        wait_en("rst_regrant_seen", 4, at);
        @(negedge clk);
        bus.inter_ready = 1'b0;
        @(negedge clk);
        bus.inter_ready = 1'b1;
        wait_done("rst_regrant_done_seen", 8, dc);
        check("rst_regrant_from_zero", 32'(bus.done), 32'b0010);
        bus.req = '0;
        @(negedge clk);

        // Requester withdraws during WAIT_BUSY; transfer still completes.
        push(int'(REQ_MOVE));
        bus.req = 4'b0010;
        wait_en("withdraw_launch_seen", 4, at);
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        bus.inter_ready = 1'b0;
        @(negedge clk);
        bus.inter_ready = 1'b1;
        wait_done("withdraw_done_seen", 8, dc);
        check("withdraw_done", 32'(bus.done), 32'b0010);
        repeat (3) @(negedge clk);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("launch_count", 32'(n_en), 32'd11);
        check("done_count", 32'(n_done), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inter_tx_arbiter.md
# inter_tx_arbiter

Shares the single interboard transmit channel between the game-control action handlers (shift, move, draw, end-turn). Each handler presents one complete message (control fields plus message type) and holds it until it is acknowledged. The arbiter grants the channel round-robin, launches exactly one `ctrl_en` pulse per granted message, tracks the interboard busy/idle cycle through `inter_ready`, and returns a one-cycle `done` pulse to the winning handler. It sits between the per-action handlers and the interboard transmitter, inside game control.

## Interface
- `NUM_REQ`, default 4: number of requesters; fixed to 4 in this design. Index 0 = shift, 1 = move, 2 = draw, 3 = end-turn.
- `BUSY_TIMEOUT`, default 16: maximum number of cycles to wait for `inter_ready` to drop after a launch.
- `clk` input 1: system clock, single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `interboard_rst` input 1: synchronous, active-high reset; same effect as `rst`.
- `req` input NUM_REQ: per-requester request level.
- `req_move_dir` input NUM_REQ: per-requester move direction.
- `req_block_x` input 5*NUM_REQ: flattened; requester i occupies bits [5i+4:5i].
- `req_block_y` input 3*NUM_REQ: flattened, same packing.
- `req_msg_type` input 4*NUM_REQ: flattened.
- `req_card` input 6*NUM_REQ: flattened.
- `req_sel_len` input 3*NUM_REQ: flattened.
- `inter_ready` input 1: interboard transmitter idle (1) or busy (0).
- `done` output NUM_REQ: one-hot, one-cycle completion pulse to the granted requester.
- `busy` output 1: high whenever the state is not IDLE.
- `ctrl_en` output 1: one-cycle launch pulse to the interboard transmitter.
- `ctrl_move_dir` output 1: latched payload field.
- `ctrl_block_x` output 5: latched payload field.
- `ctrl_block_y` output 3: latched payload field.
- `ctrl_msg_type` output 4: latched payload field.
- `ctrl_card` output 6: latched payload field.
- `ctrl_sel_len` output 3: latched payload field.

## Operation
- **States:** IDLE, SEND, WAIT_BUSY, WAIT_DONE, DONE.
- **IDLE:**
  - Acts only when `|req` is set and `inter_ready` is 1.
  - Picks the first requester with `req` high, searching from `rr_ptr` upward with wrap-around.
  - Latches that requester's payload into the `ctrl_*` registers and its index into `grant_idx`, then goes to SEND.
  - If `inter_ready` is 0, stays in IDLE regardless of `req`.
- **SEND:** `ctrl_en`=1 for exactly this cycle; clears the timeout counter; goes to WAIT_BUSY.
- **WAIT_BUSY:**
  - `inter_ready`==0: go to WAIT_DONE.
  - Otherwise increment the counter; when it reaches `BUSY_TIMEOUT`-1, go to DONE (the transfer was shorter than one sample).
- **WAIT_DONE:** stays until `inter_ready`==1, then goes to DONE. No timeout here.
- **DONE:**
  - `done[grant_idx]`=1 for this cycle only.
  - `rr_ptr` ← (`grant_idx`+1) mod `NUM_REQ`.
  - Goes to IDLE.
- **Requester contract:** hold `req` and payload stable until `done`, then drop `req` the cycle after `done`. A `req` still high in the cycle after DONE is treated as a new message.
- **Dropped request:** if `req[grant_idx]` falls mid-transfer, it is ignored; the message completes and `done` still pulses.
- **Payload hold:** `ctrl_*` fields stay at their latched values from SEND until the next grant. They do not return to 0 in IDLE.
- **Reset:** `rst` or `interboard_rst` puts every output and register at 0 and the state at IDLE on the next edge, including when asserted mid-transfer. No `done` is issued for the aborted message.

## Timing
- All outputs are registered.
- Grant latency: `req` is seen in IDLE at cycle t, so `ctrl_en` is high in cycle t+1.
- Minimum transaction: 4 cycles plus the interboard busy time.
- Next grant: evaluated in the IDLE cycle after DONE, so the earliest next `ctrl_en` is DONE+2.
- Simultaneous requests with `rr_ptr`=0 and all four high: grant order is 0, 1, 2, 3, then 0 again.
- `busy` rises in the cycle SEND is entered and falls in the IDLE cycle after DONE.

## Structure
- Add to the shared message-macro include:
  - Field widths: X=5, Y=3, MSG=4, CARD=6, SEL=3.
  - Requester index constants: `REQ_SHIFT`, `REQ_MOVE`, `REQ_DRAW`, `REQ_END`.
- Add to the game-macro include: the state encodings for this FSM.
- One sub-module, `rr_select`, combinational:
  - Inputs: `req` vector and `rr_ptr`.
  - Outputs: `valid` and the winner index.
- The FSM, payload mux/latch and timeout counter stay in the top module.

## Test plan
- **Single request:** `req`=4'b0001 with block_x=7, msg_type=3, `inter_ready` dropping 2 cycles after launch for 5 cycles:
  - `ctrl_en` is a single pulse the cycle after `req`, with `ctrl_block_x`=7 and `ctrl_msg_type`=3.
  - `done`=4'b0001 the cycle after `inter_ready` returns high.
- **Round-robin fairness:** `req`=4'b1111 held, each requester re-raising `req` after its `done`:
  - Grants occur in order 0, 1, 2, 3, 0.
  - Never two `ctrl_en` pulses without an intervening `done`.
- **Timeout:** `inter_ready` stays 1 after launch. `done` pulses exactly `BUSY_TIMEOUT`+1 cycles after `ctrl_en`.
- **Channel busy at request:** `req`=4'b0100 while `inter_ready`=0. No `ctrl_en` until `inter_ready` has been 1 for one cycle; the grant then goes to index 2.
- **Reset mid-transfer:** `interboard_rst` asserted in WAIT_DONE:
  - Next cycle: all outputs 0, state IDLE, no `done`.
  - A re-asserted `req` is served from `rr_ptr`=0.
- **Request withdrawal:** `req[1]` dropped during WAIT_BUSY. The transfer still completes and `done[1]` pulses.
